// File: rtl/display_buffer_pkg.sv
// Shared definitions for the display-buffer ingest block: control bit map,
// FSM state type, RGB pixel layout and the gamma table used by DISPLAY_GAMMA_EN.
package display_buffer_pkg;

  localparam int CTRL_WR     = 0;
  localparam int CTRL_SWAP   = 1;
  localparam int CTRL_CLR    = 2;
  localparam int CTRL_ERRCLR = 7;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } pixel_t;

  typedef logic [7:0] gamma_lut_t [256];

  // Gamma 2.0 curve, rounded: out = round(in^2 / 255)
  function automatic gamma_lut_t gamma_build();
    gamma_lut_t t;
    for (int i = 0; i < 256; i++) begin
      t[i] = 8'(((i * i) + 127) / 255);
    end
    return t;
  endfunction

  localparam gamma_lut_t GAMMA_LUT = gamma_build();

endpackage

// File: rtl/display_buffer_dpram.sv
// Simple dual-port (1W/1R) synchronous RAM written for clean block-RAM inference.
// Only the read output register is reset; the array keeps its contents.
module display_buffer_dpram #(
  parameter int AW = 12,
  parameter int DW = 24
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [DW-1:0] r_rdata;

  // Write port
  always_ff @(posedge clk) begin
    if (we) begin
      r_mem[waddr] <= wdata;
    end
  end

  // Registered read port with synchronous reset of the output register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else begin
      r_rdata <= r_mem[raddr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/display_buffer_ingest.sv
// Turns CPU PIO control toggles into writes, clears and tear-free page flips on a
// double-buffered frame RAM. Optional output gamma stage: define DISPLAY_GAMMA_EN.
module display_buffer_ingest
  import display_buffer_pkg::*;
#(
  parameter int ADDR_W = 11,
  parameter int DATA_W = 24,
  parameter int CTRL_W = 8
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic [ADDR_W-1:0] display_buffer_addr_export,
  input  logic [DATA_W-1:0] display_buffer_data_export,
  input  logic [CTRL_W-1:0] display_buffer_ctrl_export,
  input  logic              frame_start,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data,
  output logic              front_sel,
  output logic              swap_pending,
  output logic              clearing,
  output logic              wr_drop
);

  localparam logic [ADDR_W-1:0] CLR_LAST = '1;

  logic [CTRL_W-1:0] r_ctrl_q;
  logic [CTRL_W-1:0] w_evt;
  logic              w_wr_evt;
  logic              w_swap_evt;
  logic              w_clr_evt;
  logic              w_errclr_evt;
  logic              w_unused_evt;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_clr_cnt;
  logic              r_front_sel;
  logic              r_swap_pending;
  logic              r_clearing;
  logic              r_wr_drop;

  logic              w_in_clear;
  logic              w_flip;
  logic              w_front_sel_next;

  logic              w_we;
  logic [ADDR_W:0]   w_waddr;
  logic [DATA_W-1:0] w_wdata;
  logic [DATA_W-1:0] w_ram_rdata;

  assign w_evt        = display_buffer_ctrl_export ^ r_ctrl_q;
  assign w_wr_evt     = w_evt[CTRL_WR];
  assign w_swap_evt   = w_evt[CTRL_SWAP];
  assign w_clr_evt    = w_evt[CTRL_CLR];
  assign w_errclr_evt = w_evt[CTRL_ERRCLR];
  assign w_unused_evt = ^w_evt;

  // Flips wait for the scanner frame boundary and are held off while clearing
  assign w_in_clear       = (r_state == CLEAR);
  assign w_flip           = r_swap_pending & frame_start & ~w_in_clear;
  assign w_front_sel_next = r_front_sel ^ w_flip;

  // Next-state logic for the clear sequencer
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (w_clr_evt) begin
          w_state_next = CLEAR;
        end else begin
          w_state_next = IDLE;
        end
      end
      CLEAR: begin
        if (r_clr_cnt == CLR_LAST) begin
          w_state_next = IDLE;
        end else begin
          w_state_next = CLEAR;
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // RAM write port: CPU writes go to the post-flip back page, clears to the current back page
  always_comb begin
    w_we    = 1'b0;
    w_waddr = '0;
    w_wdata = '0;
    if (!reset_reset_n) begin
      w_we = 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_wr_evt) begin
            w_we    = 1'b1;
            w_waddr = {~w_front_sel_next, display_buffer_addr_export};
            w_wdata = display_buffer_data_export;
          end else begin
            w_we = 1'b0;
          end
        end
        CLEAR: begin
          w_we    = 1'b1;
          w_waddr = {~r_front_sel, r_clr_cnt};
          w_wdata = '0;
        end
        default: w_we = 1'b0;
      endcase
    end
  end

  // Control state registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_ctrl_q       <= display_buffer_ctrl_export;
      r_state        <= IDLE;
      r_clr_cnt      <= '0;
      r_front_sel    <= 1'b0;
      r_swap_pending <= 1'b0;
      r_clearing     <= 1'b0;
      r_wr_drop      <= 1'b0;
    end else begin
      r_ctrl_q       <= display_buffer_ctrl_export;
      r_state        <= w_state_next;
      r_clearing     <= (w_state_next == CLEAR);
      r_front_sel    <= w_front_sel_next;
      r_swap_pending <= w_swap_evt | (r_swap_pending & ~w_flip);
      if (w_in_clear) begin
        r_clr_cnt <= r_clr_cnt + ADDR_W'(1);
      end else begin
        r_clr_cnt <= '0;
      end
      if (w_wr_evt && w_in_clear) begin
        r_wr_drop <= 1'b1;
      end else if (w_errclr_evt) begin
        r_wr_drop <= 1'b0;
      end else begin
        r_wr_drop <= r_wr_drop;
      end
    end
  end

  display_buffer_dpram #(
    .AW (ADDR_W + 1),
    .DW (DATA_W)
  ) u_ram (
    .clk   (clk_clk),
    .rst_n (reset_reset_n),
    .we    (w_we),
    .waddr (w_waddr),
    .wdata (w_wdata),
    .raddr ({r_front_sel, rd_addr}),
    .rdata (w_ram_rdata)
  );

`ifdef DISPLAY_GAMMA_EN
  pixel_t            w_px;
  logic [DATA_W-1:0] r_gamma;

  assign w_px = pixel_t'(w_ram_rdata);

  // Per-channel gamma correction, one extra cycle of read latency
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      r_gamma <= '0;
    end else begin
      r_gamma <= {GAMMA_LUT[w_px.r], GAMMA_LUT[w_px.g], GAMMA_LUT[w_px.b]};
    end
  end

  assign rd_data = r_gamma;
`else
  assign rd_data = w_ram_rdata;
`endif

  assign front_sel    = r_front_sel;
  assign swap_pending = r_swap_pending;
  assign clearing     = r_clearing;
  assign wr_drop      = r_wr_drop;

endmodule

// File: tb/tb_display_buffer_ingest.sv
// Self-checking bench for display_buffer_ingest: directed plan sequences, a vector
// table and randomized traffic against a page/array reference model.
module tb_display_buffer_ingest;
  import display_buffer_pkg::*;

  localparam int AW = 11;
  localparam int DW = 24;
  localparam int CW = 8;
  localparam int PAGE = 1 << AW;
`ifdef DISPLAY_GAMMA_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic [AW-1:0] addr;
  logic [DW-1:0] data;
  logic [CW-1:0] ctrl;
  logic          fs;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          front_sel, swap_pending, clearing, wr_drop;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [DW-1:0] mm [0:2*PAGE-1];
  bit            mv [0:2*PAGE-1];
  bit            m_front, m_pend, m_drop;
  int            m_left, m_idx;
  logic [CW-1:0] m_prev;
  logic [DW-1:0] m_rd, m_g;
  bit            m_rdv, m_gv;

  display_buffer_ingest #(.ADDR_W(AW), .DATA_W(DW), .CTRL_W(CW)) dut (
    .clk_clk                    (clk),
    .reset_reset_n              (rst_n),
    .display_buffer_addr_export (addr),
    .display_buffer_data_export (data),
    .display_buffer_ctrl_export (ctrl),
    .frame_start                (fs),
    .rd_addr                    (rd_addr),
    .rd_data                    (rd_data),
    .front_sel                  (front_sel),
    .swap_pending               (swap_pending),
    .clearing                   (clearing),
    .wr_drop                    (wr_drop)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] exp_px(input logic [DW-1:0] v);
`ifdef DISPLAY_GAMMA_EN
    return {GAMMA_LUT[v[23:16]], GAMMA_LUT[v[15:8]], GAMMA_LUT[v[7:0]]};
`else
    return v;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock edge: advance the model with the inputs currently driven, then compare.
  task automatic step();
    logic [CW-1:0] evt;
    bit clr_now, flip, fnext, we;
    int ridx, widx;
    if (!rst_n) begin
      m_front = 1'b0; m_pend = 1'b0; m_drop = 1'b0; m_left = 0;
      m_rd = '0; m_rdv = 1'b1; m_g = '0; m_gv = 1'b1;
      m_prev = ctrl;
    end else begin
      evt     = ctrl ^ m_prev;
      clr_now = (m_left > 0);
      flip    = m_pend && fs && !clr_now;
      fnext   = m_front ^ flip;
      ridx    = (int'(m_front) << AW) + int'(rd_addr);
      we = 1'b0; widx = 0;
      if (clr_now) begin
        we = 1'b1; widx = (int'(!m_front) << AW) + m_idx;
      end else if (evt[0]) begin
        we = 1'b1; widx = (int'(!fnext) << AW) + int'(addr);
      end
      m_g  = exp_px(m_rd); m_gv = m_rdv;
      m_rd = mm[ridx];     m_rdv = mv[ridx] && !(we && widx == ridx);
      if (we) begin
        mm[widx] = clr_now ? '0 : data;
        mv[widx] = 1'b1;
      end
      if (clr_now) begin
        m_idx++; m_left--;
      end else if (evt[2]) begin
        m_left = PAGE; m_idx = 0;
      end
      if (clr_now && evt[0]) m_drop = 1'b1;
      else if (evt[7]) m_drop = 1'b0;
      if (evt[1]) m_pend = 1'b1;
      else if (flip) m_pend = 1'b0;
      m_front = fnext;
      m_prev  = ctrl;
    end
    @(posedge clk);
    #1;
    check("front_sel", 32'(front_sel), 32'(m_front));
    check("swap_pending", 32'(swap_pending), 32'(m_pend));
    check("clearing", 32'(clearing), 32'(m_left > 0));
    check("wr_drop", 32'(wr_drop), 32'(m_drop));
    if (LAT == 2) begin
      if (m_gv) check("rd_data", 32'(rd_data), 32'(m_g));
    end else begin
      if (m_rdv) check("rd_data", 32'(rd_data), 32'(m_rd));
    end
  endtask

  task automatic tgl(input int bitn);
    ctrl[bitn] = ~ctrl[bitn];
    step();
  endtask

  task automatic write_px(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a; data = d;
    tgl(0);
  endtask

  task automatic flip_page();
    tgl(1);
    fs = 1'b1; step(); fs = 1'b0;
  endtask

  task automatic read_px(input logic [AW-1:0] a, output logic [DW-1:0] v);
    rd_addr = a;
    repeat (LAT) step();
    v = rd_data;
  endtask

  typedef struct {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    logic [DW-1:0] exp;
  } vec_t;

  initial begin
    vec_t          tbl [6];
    logic [DW-1:0] v;
    logic [CW-1:0] t;
    int            n;
    bit            f0;

    tbl[0] = '{a: 11'h000, d: 24'h0000FF, exp: 24'h0000FF};
    tbl[1] = '{a: 11'h7FF, d: 24'h00FF00, exp: 24'hABCDEF};
    tbl[2] = '{a: 11'h400, d: 24'hFF0000, exp: 24'hFF0000};
    tbl[3] = '{a: 11'h3FF, d: 24'hFFFFFF, exp: 24'hFFFFFF};
    tbl[4] = '{a: 11'h155, d: 24'h808080, exp: 24'h808080};
    tbl[5] = '{a: 11'h7FF, d: 24'hABCDEF, exp: 24'hABCDEF};

    for (int i = 0; i < 2*PAGE; i++) mv[i] = 1'b0;
    rst_n = 1'b0; addr = '0; data = '0; ctrl = '0; fs = 1'b0; rd_addr = '0;
    m_prev = '0;
    step(); step();
    check("reset_rd_data", 32'(rd_data), 32'h0);
    check("reset_front_sel", 32'(front_sel), 32'h0);
    rst_n = 1'b1;
    step();

    // Plan 1: write, flip, read back
    write_px(11'h005, 24'hFF8000);
    flip_page();
    check("p1_front_sel", 32'(front_sel), 32'h1);
    read_px(11'h005, v);
    check("p1_rd_data", 32'(v), 32'(exp_px(24'hFF8000)));

    // Plan 2: double swap toggle absorbed into one flip
    tgl(1); tgl(1); step();
    check("p2_pending", 32'(swap_pending), 32'h1);
    fs = 1'b1; step(); fs = 1'b0;
    check("p2_front", 32'(front_sel), 32'h0);
    check("p2_pending_clr", 32'(swap_pending), 32'h0);
    step();
    check("p2_one_flip", 32'(front_sel), 32'h0);

    // Plan 3: full clear with dropped write
    tgl(2);
    n = 0;
    while (clearing && n < 5000) begin
      n++;
      if (n == 100) begin
        addr = 11'h010; data = 24'h123456; ctrl[0] = ~ctrl[0];
      end
      step();
    end
    check("p3_clear_cycles", 32'(n), 32'd2048);
    check("p3_wr_drop", 32'(wr_drop), 32'h1);
    flip_page();
    for (int a = 0; a < PAGE; a++) begin
      read_px(AW'(a), v);
      check("p3_cleared", 32'(v), 32'(exp_px(24'h0)));
    end
    tgl(7);
    check("p3_errclr", 32'(wr_drop), 32'h0);

    // Plan 4: write coinciding with flip lands in the new back page
    tgl(1);
    f0 = front_sel;
    addr = 11'h033; data = 24'h123456; ctrl[0] = ~ctrl[0]; fs = 1'b1;
    step(); fs = 1'b0;
    check("p4_flipped", 32'(front_sel), 32'(!f0));
    flip_page();
    read_px(11'h033, v);
    check("p4_old_front", 32'(v), 32'(exp_px(24'h123456)));

    // Plan 5: reset mid-clear with CLR bit held high
    rst_n = 1'b0; ctrl[2] = 1'b0; step(); rst_n = 1'b1; step();
    tgl(2);
    repeat (499) step();
    check("p5_clearing", 32'(clearing), 32'h1);
    rst_n = 1'b0; step(); step(); rst_n = 1'b1;
    repeat (4) step();
    check("p5_no_restart", 32'(clearing), 32'h0);
    check("p5_front", 32'(front_sel), 32'h0);
    check("p5_pending", 32'(swap_pending), 32'h0);
    check("p5_ctrl_high", 32'(ctrl[2]), 32'h1);

`ifdef DISPLAY_GAMMA_EN
    // Plan 6: gamma path
    write_px(11'h077, 24'h808080);
    flip_page();
    read_px(11'h077, v);
    check("p6_gamma", 32'(v), 32'({GAMMA_LUT[8'h80], GAMMA_LUT[8'h80], GAMMA_LUT[8'h80]}));
    flip_page();
`endif

    // Vector table: later writes to the same address overwrite earlier ones
    for (int i = 0; i < 6; i++) write_px(tbl[i].a, tbl[i].d);
    flip_page();
    for (int i = 0; i < 6; i++) begin
      read_px(tbl[i].a, v);
      check("tbl_rd", 32'(v), 32'(exp_px(tbl[i].exp)));
    end

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      addr    = AW'($urandom);
      data    = DW'($urandom);
      rd_addr = AW'($urandom);
      fs      = ($urandom_range(0, 9) == 0);
      t = '0;
      t[0] = ($urandom_range(0, 2) == 0);
      t[1] = !fs && ($urandom_range(0, 19) == 0);
      t[2] = ($urandom_range(0, 1199) == 0);
      t[7] = ($urandom_range(0, 29) == 0);
      t[6:3] = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'h0;
      ctrl = ctrl ^ t;
      step();
    end
    fs = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/display_buffer_ingest.md
Name: display_buffer_ingest

Overview:
- Consumes the three display-buffer PIO exports (address, RGB data, control) from the CPU system.
- Turns control-bit toggles into writes, clears and page flips on a double-buffered frame RAM.
- A downstream LED scanner reads the front page through a synchronous read port.
- Page flips are deferred to the scanner's frame boundary so the panel never tears.

Parameters:
ADDR_W, 11, pixel address width; each page holds 2^ADDR_W words
DATA_W, 24, pixel width, {R[23:16], G[15:8], B[7:0]}
CTRL_W, 8, control PIO width

Ports:
clk_clk  in  1  system clock; PIO exports are already in this domain
reset_reset_n  in  1  synchronous, active-low reset
display_buffer_addr_export  in  ADDR_W  pixel address from CPU PIO
display_buffer_data_export  in  DATA_W  pixel data from CPU PIO
display_buffer_ctrl_export  in  CTRL_W  control bits: [0] WR_TGL, [1] SWAP_TGL, [2] CLR_TGL, [7] ERRCLR_TGL
frame_start  in  1  single-cycle pulse from scanner at frame boundary
rd_addr  in  ADDR_W  scanner read address, front page
rd_data  out  DATA_W  front-page pixel
front_sel  out  1  page currently shown
swap_pending  out  1  flip requested, not yet taken
clearing  out  1  back-page clear in progress
wr_drop  out  1  sticky: a write was dropped

Behaviour:
- Reset, synchronous and active-low: front_sel=0, swap_pending=0, clearing=0, wr_drop=0, rd_data=0, state IDLE. ctrl_q loads the current control value, so no spurious event fires after reset. RAM contents are retained, not cleared.
- Event detection:
  - ctrl_q registers the control export every cycle.
  - evt = ctrl ^ ctrl_q per bit, so an event is any toggle, either edge.
  - addr and data are sampled in the same cycle the WR_TGL toggle is seen; software must set them before toggling.
- Write (WR_TGL event, state IDLE): write data to RAM[{~front_sel_next, addr}] in that same cycle. front_sel_next is the post-flip value, so a write coinciding with a flip lands in the new back page.
- Write during CLEAR: dropped; wr_drop <= 1.
- ERRCLR_TGL: wr_drop <= 0. If a drop happens in the same cycle, set wins.
- SWAP_TGL: swap_pending <= 1. A second toggle while pending is absorbed; still one flip.
- Flip: when swap_pending && frame_start && state!=CLEAR: front_sel toggles and swap_pending <= 0 on the same edge. A flip is never taken during a clear.
- FSM:
  - IDLE -> CLEAR on CLR_TGL: clr_cnt=0, clearing=1.
  - CLEAR: write 0 to RAM[{~front_sel, clr_cnt}] each cycle, clr_cnt++.
  - At clr_cnt == 2^ADDR_W-1: write the final word, then return to IDLE with clearing=0. Total 2^ADDR_W cycles.
  - CLR_TGL during CLEAR: ignored, no restart.
- Read port: rd_data <= RAM[{front_sel, rd_addr}], 1-cycle latency. A read in the flip cycle uses the pre-flip front_sel.
- RAM: true simple dual-port (1W/1R), 2^(ADDR_W+1) x DATA_W, inferred block RAM. Read-during-write to the same address is a don't-care, since write and read always target different pages except at the flip edge.
- Reset mid-CLEAR: clear aborts and the back page is left partially cleared; software must reissue CLR_TGL.

Optional Feature:
- Macro DISPLAY_GAMMA_EN.
- Defined: a gamma LUT (256x8, per channel, same table) is applied to rd_data in an extra register stage. Read latency becomes 2 cycles; the reset value of that stage is 0.
- Undefined: raw RAM data, latency 1.

Decomposition:
- Package display_buffer_pkg:
  - ctrl bit index constants (CTRL_WR, CTRL_SWAP, CTRL_CLR, CTRL_ERRCLR)
  - state enum typedef {IDLE, CLEAR}
  - pixel_t typedef (24-bit RGB struct)
  - GAMMA_LUT constant array
- Sub-module display_buffer_dpram: parameterised 1W/1R synchronous RAM, so the block RAM is inferred cleanly.

Test Plan:
1. Reset, then addr=0x005, data=0xFF8000, toggle ctrl[0]; pulse SWAP, then frame_start → front_sel=1. rd_addr=0x005 gives rd_data=0xFF8000 one cycle later.
2. Toggle ctrl[1] twice without frame_start → swap_pending=1 stays set. One frame_start → exactly one flip, swap_pending=0.
3. Toggle ctrl[2] → clearing high for exactly 2048 cycles. A WR toggle at cycle 100 → wr_drop=1. Flip afterwards → all 2048 reads return 0. Toggle ctrl[7] → wr_drop=0.
4. WR toggle in the same cycle as a flip-enabling frame_start → data appears in the new back page (old front), not on the display.
5. Assert reset_reset_n=0 at clear cycle 500 with ctrl[2] still high → no CLEAR restart after release; front_sel=0; no event fires.
6. With DISPLAY_GAMMA_EN defined: stored 0x808080 → rd_data equals GAMMA_LUT[0x80] per channel, 2 cycles after rd_addr.
